// File: rtl/bnn_sram_arbiter_if.sv
// bnn_sram_arbiter_if: core, host and SRAM-side signals of the data SRAM arbiter
//   slave  : arbiter view (takes requests, drives grants, read returns and SRAM controls)
//   master : environment view (core, host and SRAM macro)
interface bnn_sram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic [ADDR_W+1:0] core_ctrl;
  logic [DATA_W-1:0] core_wdata;
  logic              core_stall;
  logic [DATA_W-1:0] core_rdata;
  logic              core_rvalid;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic [ADDR_W+1:0] sram_ctrl;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  modport slave (
    input  core_ctrl, core_wdata, host_req, host_we, host_addr, host_wdata, sram_rdata,
    output core_stall, core_rdata, core_rvalid, host_gnt, host_rdata, host_rvalid, sram_ctrl, sram_wdata
  );
  modport master (
    output core_ctrl, core_wdata, host_req, host_we, host_addr, host_wdata, sram_rdata,
    input  core_stall, core_rdata, core_rvalid, host_gnt, host_rdata, host_rvalid, sram_ctrl, sram_wdata
  );
endinterface

// File: rtl/bnn_sram_arbiter.sv
// bnn_sram_arbiter: shares the single-port data SRAM between the core port (priority) and a host preload port
//   clk, rst : clock, asynchronous active-high reset
//   bus      : core_ctrl/core_wdata/core_stall/core_rdata/core_rvalid (core port),
//              host_req/host_we/host_addr/host_wdata/host_gnt/host_rdata/host_rvalid (host port),
//              sram_ctrl/sram_wdata (registered SRAM drive), sram_rdata (SRAM output)
module bnn_sram_arbiter #(
  parameter int          ADDR_W       = 13,
  parameter int          DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int          CNT_W        = 4
) (
  input logic                  clk,
  input logic                  rst,
  bnn_sram_arbiter_if.slave    bus
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);
  logic              w_core_req, w_force, w_host_gnt, w_core_gnt, w_rd;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [ADDR_W+1:0] r_ctrl;
  logic [DATA_W-1:0] r_wdata;
  // read tag pipe: bit 0 = access cycle, bit 1 = return cycle; r_tag_h marks host ownership
  logic [1:0]        r_tag_v, r_tag_h;
  always_comb begin
    w_core_req = ~bus.core_ctrl[ADDR_W];
    w_force    = (STARVE_LIMIT != 0) && (r_wait_cnt >= LIM);
    w_host_gnt = bus.host_req && (w_force || !w_core_req);
    w_core_gnt = w_core_req && !w_host_gnt;
    w_rd       = w_host_gnt ? !bus.host_we : (w_core_gnt && bus.core_ctrl[ADDR_W+1]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_wait_cnt <= '0;
    else if (!bus.host_req || w_host_gnt) r_wait_cnt <= '0;
    else if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + 1'b1;
  // idle keeps the last address/wdata so the SRAM pins only toggle CEN/WEN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ctrl  <= {2'b11, {ADDR_W{1'b0}}};
      r_wdata <= '0;
    end else if (w_host_gnt) begin
      r_ctrl  <= {~bus.host_we, 1'b0, bus.host_addr};
      r_wdata <= bus.host_wdata;
    end else if (w_core_gnt) begin
      r_ctrl  <= bus.core_ctrl;
      r_wdata <= bus.core_wdata;
    end else
      r_ctrl[ADDR_W+1:ADDR_W] <= 2'b11;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_tag_v <= '0;
      r_tag_h <= '0;
    end else begin
      r_tag_v <= {r_tag_v[0], w_rd};
      r_tag_h <= {r_tag_h[0], w_host_gnt};
    end
  assign bus.core_stall  = w_core_req && w_host_gnt;
  assign bus.host_gnt    = w_host_gnt;
  assign bus.sram_ctrl   = r_ctrl;
  assign bus.sram_wdata  = r_wdata;
  assign bus.core_rdata  = bus.sram_rdata;
  assign bus.host_rdata  = bus.sram_rdata;
  assign bus.core_rvalid = r_tag_v[1] && !r_tag_h[1];
  assign bus.host_rvalid = r_tag_v[1] && r_tag_h[1];
endmodule

// File: tb/tb_bnn_sram_arbiter.sv
// tb_bnn_sram_arbiter: directed and random checks of bnn_sram_arbiter against a transaction-level model
module tb_bnn_sram_arbiter;
  localparam int LIM = 8;
  typedef struct {
    int          due;
    bit          host;
    logic [15:0] data;
  } rd_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  bnn_sram_arbiter_if #(.ADDR_W(13), .DATA_W(16)) bus ();
  bnn_sram_arbiter #(.ADDR_W(13), .DATA_W(16), .STARVE_LIMIT(LIM), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [15:0] sram [int];
  logic [15:0] ref_mem [int];
  rd_t         q[$];
  int          waited, cyc, errs, checks;
  logic [14:0] exp_ctrl;
  logic [15:0] exp_wd;
  bit          last_stall;
  function automatic logic [15:0] init_val(int a);
    return (a == 16) ? 16'hBEEF : (16'(a) ^ 16'hC3C3);
  endfunction
  always @(posedge clk)
    if (!bus.sram_ctrl[13]) begin
      if (bus.sram_ctrl[14])
        bus.sram_rdata <= sram.exists(int'(bus.sram_ctrl[12:0])) ? sram[int'(bus.sram_ctrl[12:0])] : init_val(int'(bus.sram_ctrl[12:0]));
      else
        sram[int'(bus.sram_ctrl[12:0])] = bus.sram_wdata;
    end
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction
  task automatic idle();
    bus.core_ctrl  = 15'h6000;
    bus.core_wdata = '0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
  endtask
  // one clock cycle: check combinational outputs and returns, then apply the granted access to the model
  task automatic tick();
    bit creq, hg, cg, ev_c, ev_h;
    logic [15:0] ed;
    int a;
    creq = !bus.core_ctrl[13];
    hg   = bus.host_req && ((waited >= LIM) || !creq);
    cg   = creq && !hg;
    ev_c = q.size() > 0 && q[0].due == cyc && !q[0].host;
    ev_h = q.size() > 0 && q[0].due == cyc && q[0].host;
    ed   = q.size() > 0 ? q[0].data : 16'h0;
    #2;
    chk("host_gnt", 32'(bus.host_gnt), 32'(hg));
    chk("core_stall", 32'(bus.core_stall), 32'(creq && hg));
    chk("core_rvalid", 32'(bus.core_rvalid), 32'(ev_c));
    chk("host_rvalid", 32'(bus.host_rvalid), 32'(ev_h));
    if (ev_c) chk("core_rdata", 32'(bus.core_rdata), 32'(ed));
    if (ev_h) chk("host_rdata", 32'(bus.host_rdata), 32'(ed));
    if (ev_c || ev_h) void'(q.pop_front());
    last_stall = creq && hg;
    @(posedge clk);
    if (hg) begin
      a = int'(bus.host_addr);
      exp_ctrl = {~bus.host_we, 1'b0, bus.host_addr};
      exp_wd = bus.host_wdata;
      if (bus.host_we) ref_mem[a] = bus.host_wdata;
      else q.push_back('{cyc + 2, 1'b1, ref_rd(a)});
    end else if (cg) begin
      a = int'(bus.core_ctrl[12:0]);
      exp_ctrl = bus.core_ctrl;
      exp_wd = bus.core_wdata;
      if (!bus.core_ctrl[14]) ref_mem[a] = bus.core_wdata;
      else q.push_back('{cyc + 2, 1'b0, ref_rd(a)});
    end else
      exp_ctrl[14:13] = 2'b11;
    waited = (hg || !bus.host_req) ? 0 : waited + 1;
    cyc++;
    #1;
    chk("sram_ctrl", 32'(bus.sram_ctrl), 32'(exp_ctrl));
    chk("sram_wdata", 32'(bus.sram_wdata), 32'(exp_wd));
  endtask
  initial begin
    int first_gnt, stalls;
    errs = 0; checks = 0; waited = 0; cyc = 0; last_stall = 0;
    exp_ctrl = 15'h6000; exp_wd = '0;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 chk("reset_ctrl", 32'(bus.sram_ctrl), 32'h6000);
    chk("reset_wdata", 32'(bus.sram_wdata), 32'h0);
    rst = 1'b0;
    repeat (2) tick();
    // core read of 0x0010 (preloaded 0xBEEF)
    bus.core_ctrl = 15'h4010;
    tick();
    chk("core_rd_ctrl", 32'(bus.sram_ctrl), 32'h4010);
    idle();
    repeat (3) tick();
    // host write then read-back of 0x1FFF, no core traffic
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 13'h1FFF; bus.host_wdata = 16'h1234;
    tick();
    bus.host_we = 1'b0;
    tick();
    idle();
    repeat (3) tick();
    // starvation: continuous core reads, host held until forced slot
    first_gnt = -1; stalls = 0;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 13'h0010;
    for (int i = 0; i < LIM + 1; i++) begin
      bus.core_ctrl = {2'b10, 13'($urandom_range(0, 31))};
      #2;
      if (bus.host_gnt && first_gnt < 0) first_gnt = i;
      if (bus.core_stall) stalls++;
      #(-0);
      tick();
    end
    chk("starve_first_gnt", 32'(first_gnt), 32'(LIM));
    chk("starve_stalls", 32'(stalls), 32'd1);
    bus.host_req = 1'b0;
    bus.core_ctrl = {2'b10, 13'h0005};
    tick();
    idle();
    repeat (3) tick();
    // alternating core and host reads
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i % 2 == 0) bus.core_ctrl = {2'b10, 13'($urandom_range(0, 31))};
      else begin bus.host_req = 1'b1; bus.host_addr = 13'($urandom_range(0, 31)); end
      tick();
    end
    idle();
    repeat (3) tick();
    // host read granted, then reset pulsed the next cycle
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 13'h1FFF;
    tick();
    idle();
    rst = 1'b1;
    #1 chk("rst_mid_ctrl", 32'(bus.sram_ctrl), 32'h6000);
    chk("rst_mid_core_rvalid", 32'(bus.core_rvalid), 32'h0);
    chk("rst_mid_host_rvalid", 32'(bus.host_rvalid), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete(); waited = 0; exp_ctrl = 15'h6000; exp_wd = '0; cyc += 10;
    repeat (4) tick();
    // random traffic on a small address window for read-after-write coverage
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        bus.core_ctrl  = {1'($urandom), ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1, 13'($urandom_range(0, 15))};
        bus.core_wdata = 16'($urandom);
      end
      bus.host_req   = $urandom_range(0, 2) != 0;
      bus.host_we    = 1'($urandom);
      bus.host_addr  = 13'($urandom_range(0, 15));
      bus.host_wdata = 16'($urandom);
      tick();
    end
    idle();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
